rnic_request_buffer: RTL and testbench
======================================

RNIC_REQUEST_BUFFER -- requirements
Module: rnic_request_buffer

Interface
REQ-001 Parameter DEPTH, default 8, number of request entries; power of two, minimum 2.
REQ-002 Parameter AF_LEVEL, default 6, occupancy at or above which almost_full asserts; range 1..DEPTH.
REQ-003 clk  input  1  single clock, all state rising-edge.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 rnic_valid  input  1  RNIC offers a request this cycle.
REQ-006 rnic_request  input  request (types_def)  request payload from RNIC.
REQ-007 rnic_ready  output  1  buffer accepts rnic_request this cycle.
REQ-008 out_valid  output  1  head entry valid; drives txn_controller in_valid.
REQ-009 out_request  output  request  head entry payload; drives txn_controller in_request.
REQ-010 txn_busy  input  1  txn_controller out_busy; stalls pop.
REQ-011 count  output  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
REQ-012 almost_full  output  1  count >= AF_LEVEL.
REQ-013 push_rd_cnt / push_wr_cnt  output  16 each  accepted read / write requests since reset, by rnic_request.req_type.

Function
REQ-014 Push event = rnic_valid && rnic_ready; rnic_ready SHALL equal !full, combinational from registered state only, with no path from rnic_valid or txn_busy.
REQ-015 Pop event = out_valid && !txn_busy; out_valid SHALL equal !empty.
REQ-016 Show-ahead: out_request SHALL present the oldest entry whenever out_valid=1 and SHALL hold stable while txn_busy=1.
REQ-017 Latency: a push into an empty buffer SHALL assert out_valid on the next cycle; no same-cycle bypass.
REQ-018 Order SHALL be strictly FIFO; no reordering, merging or dropping.
REQ-019 Read and write pointers SHALL be $clog2(DEPTH) bits and wrap modulo DEPTH.
REQ-020 Simultaneous push and pop SHALL leave count unchanged; when full, a pop frees the slot but rnic_ready rises only on the following cycle.
REQ-021 Push on empty with txn_busy=1 SHALL be accepted; the entry waits until txn_busy=0.
REQ-022 rnic_valid while rnic_ready=0 SHALL have no effect; the RNIC holds the request.
REQ-023 count SHALL update one cycle after each event: +1 push only, -1 pop only, 0 for both or neither.
REQ-024 almost_full SHALL be registered, consistent with the registered count.
REQ-025 push_rd_cnt / push_wr_cnt SHALL increment on a push of the matching req_type and wrap from 16'hFFFF to 0.

Reset
REQ-026 On rst_n=0: pointers, count, almost_full, out_valid and both push counters SHALL clear to 0, and rnic_ready SHALL read 1, asynchronously.
REQ-027 Storage contents need no reset; out_request is don't-care while out_valid=0.
REQ-028 Reset mid-operation SHALL discard all buffered entries; the first cycle after release behaves as empty.

Structure
REQ-029 request typedef and the req_type encoding SHALL come from types_def; rnic_buf_depth (default 8) SHALL be added to types_def.
REQ-030 No sub-module: storage is an inline register array, with pointers and count in the same module.

Verification
REQ-031 Single push, txn_busy=0: req A at cycle 0 -> out_valid=1 with A at cycle 1, popped; count 0 at cycle 2.
REQ-032 Fill with txn_busy=1: 8 pushes -> count=8, rnic_ready=0, almost_full=1 from count=6; 9th request held and not lost.
REQ-033 Full plus pop: release txn_busy for one cycle at count=8 -> oldest popped, rnic_ready=1 next cycle, held request accepted, order preserved.
REQ-034 Continuous push and pop for 20 cycles -> count constant at 1, outputs match inputs in order, pointers wrap twice.
REQ-035 Mixed types: 3 reads and 5 writes accepted -> push_rd_cnt=3, push_wr_cnt=5.
REQ-036 rst_n pulse at count=5 -> out_valid=0 and count=0 immediately; next push appears after 1 cycle.

Source files
------------

// File: rtl/types_def.sv
// Shared RNIC request types and buffer sizing used by the request path.
package types_def;

  localparam int rnic_buf_depth = 8;

  typedef enum logic {
    REQ_READ  = 1'b0,
    REQ_WRITE = 1'b1
  } req_type_e;

  typedef struct packed {
    req_type_e   req_type;
    logic [7:0]  tag;
    logic [31:0] addr;
  } request;

endpackage

// File: rtl/rnic_request_buffer.sv
// Show-ahead FIFO between the RNIC request port and the transaction controller,
// with occupancy, almost-full flag and per-type accepted-request counters.
module rnic_request_buffer
  import types_def::*;
#(
  parameter int DEPTH    = rnic_buf_depth,
  parameter int AF_LEVEL = 6
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     rnic_valid,
  input  request                   rnic_request,
  output logic                     rnic_ready,
  output logic                     out_valid,
  output request                   out_request,
  input  logic                     txn_busy,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     almost_full,
  output logic [15:0]              push_rd_cnt,
  output logic [15:0]              push_wr_cnt
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
  localparam logic [CW-1:0] AF_CNT   = CW'(AF_LEVEL);

  request          mem [DEPTH];
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;
  logic [CW-1:0]   count_next;
  logic            push;
  logic            pop;

  // Handshake flags derive only from registered occupancy, never from
  // rnic_valid or txn_busy, so no combinational path crosses the buffer.
  assign rnic_ready  = (count != FULL_CNT);
  assign out_valid   = (count != '0);
  assign push        = rnic_valid && rnic_ready;
  assign pop         = out_valid && !txn_busy;
  assign out_request = mem[rd_ptr];

  always_comb begin
    count_next = count;
    case ({push, pop})
      2'b10:   count_next = count + CW'(1);
      2'b01:   count_next = count - CW'(1);
      default: count_next = count;
    endcase
  end

  // NOTE: control state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      almost_full <= 1'b0;
      push_rd_cnt <= '0;
      push_wr_cnt <= '0;
    end else begin
      count       <= count_next;
      almost_full <= (count_next >= AF_CNT);
      if (push) begin
        wr_ptr <= wr_ptr + PW'(1);
        if (rnic_request.req_type == REQ_READ) push_rd_cnt <= push_rd_cnt + 16'd1;
        else                                   push_wr_cnt <= push_wr_cnt + 16'd1;
      end
      if (pop) rd_ptr <= rd_ptr + PW'(1);
    end
  end

  // NOTE: the entry array has no reset; its contents are only observed
  // through out_request while out_valid is high, i.e. after a write.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= rnic_request;
  end

endmodule

// File: tb/tb_rnic_request_buffer.sv
// Directed bench for rnic_request_buffer: the driver queues expected entries on
// accept, and an independent monitor checks every pop against that queue.
module tb_rnic_request_buffer;
  import types_def::*;

  localparam int DEPTH    = 8;
  localparam int AF_LEVEL = 6;
  localparam int CW       = $clog2(DEPTH) + 1;

  logic          clk;
  logic          rst_n;
  logic          rnic_valid;
  request        rnic_request;
  logic          rnic_ready;
  logic          out_valid;
  request        out_request;
  logic          txn_busy;
  logic [CW-1:0] count;
  logic          almost_full;
  logic [15:0]   push_rd_cnt;
  logic [15:0]   push_wr_cnt;

  request exp_q[$];
  int     n_cmp = 0;
  int     n_err = 0;

  rnic_request_buffer #(.DEPTH(DEPTH), .AF_LEVEL(AF_LEVEL)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .rnic_valid   (rnic_valid),
    .rnic_request (rnic_request),
    .rnic_ready   (rnic_ready),
    .out_valid    (out_valid),
    .out_request  (out_request),
    .txn_busy     (txn_busy),
    .count        (count),
    .almost_full  (almost_full),
    .push_rd_cnt  (push_rd_cnt),
    .push_wr_cnt  (push_wr_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic request mk(input req_type_e t, input logic [7:0] tag);
    request r;
    r.req_type = t;
    r.tag      = tag;
    r.addr     = {8'h40, tag, ~tag, 8'h00};
    return r;
  endfunction

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  // Offers one request until accepted (bounded); records it as expected output.
  task automatic send(input request r);
    bit done;
    done         = 1'b0;
    rnic_request = r;
    rnic_valid   = 1'b1;
    for (int i = 0; i < 50 && !done; i++) begin
      @(negedge clk);
      if (rnic_ready) begin
        exp_q.push_back(r);
        done = 1'b1;
      end
      cycle();
    end
    rnic_valid = 1'b0;
    if (!done) begin
      n_cmp++;
      n_err++;
      $display("FAIL send_timeout: tag %0h never accepted", r.tag);
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 40 && exp_q.size() != 0; i++) cycle();
    check("drain_queue_empty", 64'(exp_q.size()), 0);
    check("drain_count", count, 0);
    check("drain_out_valid", out_valid, 0);
  endtask

  // Monitor: every pop must deliver the oldest outstanding expected entry.
  always @(negedge clk) begin
    if (rst_n && out_valid && !txn_busy) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_pop: got %0h expected nothing", out_request);
      end else begin
        check("pop_order", out_request, exp_q[0]);
        void'(exp_q.pop_front());
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    request     held;
    req_type_e  mix [8];
    mix = '{REQ_READ, REQ_WRITE, REQ_WRITE, REQ_READ, REQ_WRITE, REQ_WRITE, REQ_READ, REQ_WRITE};

    rst_n        = 1'b0;
    rnic_valid   = 1'b0;
    txn_busy     = 1'b0;
    rnic_request = '0;
    #8;
    check("rst_out_valid", out_valid, 0);
    check("rst_count", count, 0);
    check("rst_ready", rnic_ready, 1);
    check("rst_almost_full", almost_full, 0);
    check("rst_rd_cnt", push_rd_cnt, 0);
    check("rst_wr_cnt", push_wr_cnt, 0);
    #4 rst_n = 1'b1;
    cycle();

    // Single push, one-cycle latency, popped immediately.
    send(mk(REQ_READ, 8'hA0));
    check("single_out_valid", out_valid, 1);
    check("single_count", count, 1);
    cycle();
    check("single_count_after_pop", count, 0);
    check("single_out_valid_after_pop", out_valid, 0);

    // Fill while stalled; almost_full from 6.
    txn_busy = 1'b1;
    for (int i = 0; i < 8; i++) begin
      check("fill_count", count, i);
      check("fill_almost_full", almost_full, (i >= AF_LEVEL) ? 1 : 0);
      send(mk((i % 2 == 1) ? REQ_WRITE : REQ_READ, 8'hB0 + 8'(i)));
    end
    check("full_count", count, 8);
    check("full_ready", rnic_ready, 0);
    check("full_almost_full", almost_full, 1);
    check("full_head", out_request, mk(REQ_READ, 8'hB0));

    // Ninth request is held off while full.
    held         = mk(REQ_WRITE, 8'hC9);
    rnic_request = held;
    rnic_valid   = 1'b1;
    cycle();
    cycle();
    check("held_count", count, 8);
    check("held_ready", rnic_ready, 0);
    check("busy_head_stable", out_request, mk(REQ_READ, 8'hB0));

    // One-cycle pop frees a slot; ready returns the cycle after.
    txn_busy = 1'b0;
    cycle();
    txn_busy = 1'b1;
    check("after_pop_count", count, 7);
    check("after_pop_ready", rnic_ready, 1);
    check("after_pop_almost_full", almost_full, 1);
    @(negedge clk);
    check("held_accept_ready", rnic_ready, 1);
    exp_q.push_back(held);
    cycle();
    rnic_valid = 1'b0;
    check("refill_count", count, 8);
    check("refill_head", out_request, mk(REQ_WRITE, 8'hB1));
    txn_busy = 1'b0;
    drain();

    // Continuous push and pop: occupancy pinned at 1 across two pointer wraps.
    for (int i = 0; i < 20; i++) begin
      rnic_request = mk((i % 3 == 0) ? REQ_READ : REQ_WRITE, 8'hD0 + 8'(i));
      rnic_valid   = 1'b1;
      @(negedge clk);
      check("stream_ready", rnic_ready, 1);
      exp_q.push_back(rnic_request);
      if (i > 0) check("stream_count", count, 1);
      cycle();
    end
    rnic_valid = 1'b0;
    drain();

    // Asynchronous reset at count=5 discards everything.
    txn_busy = 1'b1;
    for (int i = 0; i < 5; i++) send(mk(REQ_WRITE, 8'hE0 + 8'(i)));
    check("prereset_count", count, 5);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_out_valid", out_valid, 0);
    check("midrst_count", count, 0);
    check("midrst_ready", rnic_ready, 1);
    check("midrst_almost_full", almost_full, 0);
    check("midrst_wr_cnt", push_wr_cnt, 0);
    exp_q.delete();
    @(negedge clk);
    #1 rst_n = 1'b1;
    cycle();
    txn_busy = 1'b0;
    check("post_rst_empty", out_valid, 0);

    // Mixed types after reset: 3 reads, 5 writes; first shows up next cycle.
    send(mk(mix[0], 8'hF0));
    check("post_rst_latency", out_valid, 1);
    for (int i = 1; i < 8; i++) send(mk(mix[i], 8'hF0 + 8'(i)));
    drain();
    check("mixed_rd_cnt", push_rd_cnt, 3);
    check("mixed_wr_cnt", push_wr_cnt, 5);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
